// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared encodings for the RV32I multi-cycle control unit:
//               FSM state encoding, opcode constants and the select/control
//               encodings driven onto the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    // Controller states, explicitly encoded on 4 bits.
    typedef enum logic [3:0] {
        c_st_fetch    = 4'd0,
        c_st_decode   = 4'd1,
        c_st_memadr   = 4'd2,
        c_st_memread  = 4'd3,
        c_st_memwb    = 4'd4,
        c_st_memwrite = 4'd5,
        c_st_execr    = 4'd6,
        c_st_execi    = 4'd7,
        c_st_aluwb    = 4'd8,
        c_st_branch   = 4'd9,
        c_st_jal      = 4'd10,
        c_st_jalr1    = 4'd11,
        c_st_jalr2    = 4'd12,
        c_st_lui      = 4'd13,
        c_st_halt     = 4'd14
    } state_t;

    // Opcodes (Inst[6:0]).
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    // ALUControl encodings.
    localparam logic [2:0] c_alu_add  = 3'd0;
    localparam logic [2:0] c_alu_sub  = 3'd1;
    localparam logic [2:0] c_alu_and  = 3'd2;
    localparam logic [2:0] c_alu_or   = 3'd3;
    localparam logic [2:0] c_alu_xor  = 3'd4;
    localparam logic [2:0] c_alu_slt  = 3'd5;
    localparam logic [2:0] c_alu_sltu = 3'd6;

    // ImmSrc encodings.
    localparam logic [2:0] c_imm_i = 3'd0;
    localparam logic [2:0] c_imm_s = 3'd1;
    localparam logic [2:0] c_imm_b = 3'd2;
    localparam logic [2:0] c_imm_j = 3'd3;
    localparam logic [2:0] c_imm_u = 3'd4;

    // ResultSrc encodings.
    localparam logic [1:0] c_res_aluout    = 2'd0;
    localparam logic [1:0] c_res_data      = 2'd1;
    localparam logic [1:0] c_res_aluresult = 2'd2;
    localparam logic [1:0] c_res_immext    = 2'd3;

    // ALUSrcA encodings.
    localparam logic [1:0] c_srca_pc    = 2'd0;
    localparam logic [1:0] c_srca_oldpc = 2'd1;
    localparam logic [1:0] c_srca_a     = 2'd2;

    // ALUSrcB encodings.
    localparam logic [1:0] c_srcb_b    = 2'd0;
    localparam logic [1:0] c_srcb_imm  = 2'd1;
    localparam logic [1:0] c_srcb_four = 2'd2;

    // True for every opcode the controller knows how to sequence.
    function automatic logic is_known_op(input logic [6:0] op);
        return (op == c_op_rtype)  || (op == c_op_itype) ||
               (op == c_op_load)   || (op == c_op_store) ||
               (op == c_op_branch) || (op == c_op_jal)   ||
               (op == c_op_jalr)   || (op == c_op_lui);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps funct3/funct7 of R-type and I-type ALU instructions onto
//               the ALUControl encoding and flags funct3 values the ALU does
//               not implement (shifts).
// Ports       : i_op            opcode Inst[6:0]
//               i_func3         Inst[14:12]
//               i_func7         Inst[31:25]
//               o_alu_control   ALU operation for EXECR/EXECI
//               o_funct_illegal funct3 not supported by the ALU
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_op,
    input  logic [2:0] i_func3,
    input  logic [6:0] i_func7,
    output logic [2:0] o_alu_control,
    output logic       o_funct_illegal
);

    logic w_is_rtype;
    logic w_unused_func7;

    assign w_is_rtype = (i_op == c_op_rtype);

    // Only funct7[5] distinguishes ADD from SUB; the other bits carry no
    // meaning for the supported operations.
    assign w_unused_func7 = ^{i_func7[6], i_func7[4:0]};

    always_comb begin
        o_alu_control   = c_alu_add;
        o_funct_illegal = 1'b0;
        case (i_func3)
            // addi has no SUB form, so funct7[5] only matters for R-type.
            3'b000:  o_alu_control = (w_is_rtype && i_func7[5]) ? c_alu_sub : c_alu_add;
            3'b111:  o_alu_control = c_alu_and;
            3'b110:  o_alu_control = c_alu_or;
            3'b100:  o_alu_control = c_alu_xor;
            3'b010:  o_alu_control = c_alu_slt;
            3'b011:  o_alu_control = c_alu_sltu;
            default: o_funct_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_controller
// Description : Main control unit of the RV32I multi-cycle core. A Moore FSM
//               sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives all
//               datapath enables and selects; only PcWrite in BRANCH depends
//               combinationally on Zero/sign.
// Ports       : clk        rising-edge clock
//               rst        asynchronous active-low reset
//               op/func3/func7  instruction fields from the IR
//               Zero/sign  ALU result == 0 / ALU result bit 31
//               RegWrite, PcWrite, IrWrite, AdrSrc, MemWrite  enables/selects
//               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl  mux selects
//               illegal    sticky illegal-instruction flag
// Config      : CTRL_ILLEGAL_TRAP_EN - when defined, illegal opcodes/functs
//               park the FSM in HALT with illegal=1 until reset; otherwise
//               they retire as a NOP and illegal is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       Zero,
    input  logic       sign,
    output logic       RegWrite,
    output logic       PcWrite,
    output logic       IrWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_t c_illegal_dest = c_st_halt;
`else
    localparam state_t c_illegal_dest = c_st_fetch;
`endif

    state_t     r_state;
    state_t     w_state_next;

    logic       w_regwrite;
    logic       w_pcwrite;
    logic       w_irwrite;
    logic       w_memwrite;
    logic [2:0] w_funct_alu;
    logic       w_funct_illegal;
    logic       w_branch_taken;
    logic       w_branch_illegal;

    alu_decoder u_alu_decoder (
        .i_op            (op),
        .i_func3         (func3),
        .i_func7         (func7),
        .o_alu_control   (w_funct_alu),
        .o_funct_illegal (w_funct_illegal)
    );

    // Branch condition resolved from the SUB result of A-B in BRANCH.
    always_comb begin
        w_branch_taken   = 1'b0;
        w_branch_illegal = 1'b0;
        case (func3)
            3'b000:  w_branch_taken = Zero;    // beq
            3'b001:  w_branch_taken = ~Zero;   // bne
            3'b100:  w_branch_taken = sign;    // blt
            3'b101:  w_branch_taken = ~sign;   // bge
            default: w_branch_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_regwrite   = 1'b0;
        w_pcwrite    = 1'b0;
        w_irwrite    = 1'b0;
        w_memwrite   = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = c_res_aluout;
        ALUSrcA      = c_srca_pc;
        ALUSrcB      = c_srcb_b;
        ImmSrc       = c_imm_i;
        ALUControl   = c_alu_add;

        case (r_state)
            c_st_fetch: begin
                w_irwrite    = 1'b1;
                ALUSrcB      = c_srcb_four;
                ResultSrc    = c_res_aluresult;
                w_pcwrite    = 1'b1;
                w_state_next = c_st_decode;
            end

            c_st_decode: begin
                // ALUOut captures OldPc+imm for a possible branch/jal target.
                ALUSrcA = c_srca_oldpc;
                ALUSrcB = c_srcb_imm;
                ImmSrc  = (op == c_op_jal) ? c_imm_j : c_imm_b;
                if (!is_known_op(op)) begin
                    w_state_next = c_illegal_dest;
                end else begin
                    case (op)
                        c_op_load,
                        c_op_store:  w_state_next = c_st_memadr;
                        c_op_rtype:  w_state_next = w_funct_illegal ? c_illegal_dest : c_st_execr;
                        c_op_itype:  w_state_next = w_funct_illegal ? c_illegal_dest : c_st_execi;
                        c_op_branch: w_state_next = c_st_branch;
                        c_op_jal:    w_state_next = c_st_jal;
                        c_op_jalr:   w_state_next = c_st_jalr1;
                        default:     w_state_next = c_st_lui;
                    endcase
                end
            end

            c_st_memadr: begin
                ALUSrcA = c_srca_a;
                ALUSrcB = c_srcb_imm;
                if (op == c_op_store) begin
                    ImmSrc       = c_imm_s;
                    w_state_next = c_st_memwrite;
                end else begin
                    ImmSrc       = c_imm_i;
                    w_state_next = c_st_memread;
                end
            end

            c_st_memread: begin
                AdrSrc       = 1'b1;
                ResultSrc    = c_res_aluout;
                w_state_next = c_st_memwb;
            end

            c_st_memwb: begin
                ResultSrc    = c_res_data;
                w_regwrite   = 1'b1;
                w_state_next = c_st_fetch;
            end

            c_st_memwrite: begin
                AdrSrc       = 1'b1;
                ResultSrc    = c_res_aluout;
                w_memwrite   = 1'b1;
                w_state_next = c_st_fetch;
            end

            c_st_execr: begin
                ALUSrcA      = c_srca_a;
                ALUSrcB      = c_srcb_b;
                ALUControl   = w_funct_alu;
                w_state_next = c_st_aluwb;
            end

            c_st_execi: begin
                ALUSrcA      = c_srca_a;
                ALUSrcB      = c_srcb_imm;
                ImmSrc       = c_imm_i;
                ALUControl   = w_funct_alu;
                w_state_next = c_st_aluwb;
            end

            c_st_aluwb: begin
                ResultSrc    = c_res_aluout;
                w_regwrite   = 1'b1;
                w_state_next = c_st_fetch;
            end

            c_st_branch: begin
                // ALUOut still holds the target from DECODE, so ResultSrc
                // selects it while the ALU compares A and B.
                ALUSrcA      = c_srca_a;
                ALUSrcB      = c_srcb_b;
                ALUControl   = c_alu_sub;
                ResultSrc    = c_res_aluout;
                w_pcwrite    = w_branch_taken & ~w_branch_illegal;
                w_state_next = w_branch_illegal ? c_illegal_dest : c_st_fetch;
            end

            // JAL and JALR2 both load PC from ALUOut while computing the link
            // value OldPc+4, which ALUWB then writes to rd.
            c_st_jal,
            c_st_jalr2: begin
                ALUSrcA      = c_srca_oldpc;
                ALUSrcB      = c_srcb_four;
                ALUControl   = c_alu_add;
                ResultSrc    = c_res_aluout;
                w_pcwrite    = 1'b1;
                w_state_next = c_st_aluwb;
            end

            c_st_jalr1: begin
                ALUSrcA      = c_srca_a;
                ALUSrcB      = c_srcb_imm;
                ImmSrc       = c_imm_i;
                w_state_next = c_st_jalr2;
            end

            c_st_lui: begin
                ImmSrc       = c_imm_u;
                ResultSrc    = c_res_immext;
                w_regwrite   = 1'b1;
                w_state_next = c_st_fetch;
            end

            c_st_halt: begin
                w_state_next = c_st_halt;
            end

            default: begin
                w_state_next = c_st_fetch;
            end
        endcase
    end

    // Write enables are gated by reset so that asserting it mid-instruction
    // suppresses any write in the same cycle, not just from the next edge.
    assign RegWrite = w_regwrite & rst;
    assign PcWrite  = w_pcwrite  & rst;
    assign IrWrite  = w_irwrite  & rst;
    assign MemWrite = w_memwrite & rst;

`ifdef CTRL_ILLEGAL_TRAP_EN
    // HALT is only left through reset, which makes the flag sticky.
    assign illegal = (r_state == c_st_halt);
`else
    assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_controller
// Description : Self-checking bench for multi_cycle_controller. Stimulus
//               pushes the expected per-cycle control vector for each
//               instruction into a queue; a monitor pops and compares one
//               entry on every falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_controller;

    localparam logic [6:0] c_r   = 7'b0110011;
    localparam logic [6:0] c_i   = 7'b0010011;
    localparam logic [6:0] c_ld  = 7'b0000011;
    localparam logic [6:0] c_st  = 7'b0100011;
    localparam logic [6:0] c_br  = 7'b1100011;
    localparam logic [6:0] c_jal = 7'b1101111;
    localparam logic [6:0] c_jlr = 7'b1100111;
    localparam logic [6:0] c_lui = 7'b0110111;
    localparam logic [6:0] c_bad = 7'b1111111;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       Zero;
    logic       sign;
    logic       RegWrite, PcWrite, IrWrite, AdrSrc, MemWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;
    logic       illegal;

    typedef struct {
        logic [17:0] vec;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    multi_cycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .func3      (func3),
        .func7      (func7),
        .Zero       (Zero),
        .sign       (sign),
        .RegWrite   (RegWrite),
        .PcWrite    (PcWrite),
        .IrWrite    (IrWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {RegWrite,PcWrite,IrWrite,AdrSrc,MemWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,illegal}
    logic [17:0] w_act;
    assign w_act = {RegWrite, PcWrite, IrWrite, AdrSrc, MemWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

    function automatic logic [17:0] ev(input logic rw, input logic pw, input logic iw,
                                       input logic ad, input logic mw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] im,
                                       input logic [2:0] al, input logic il);
        return {rw, pw, iw, ad, mw, rs, sa, sb, im, al, il};
    endfunction

    // Hand-derived rows of the control table.
    logic [17:0] row_reset, row_fetch, row_memread, row_memwb, row_memwrite;
    logic [17:0] row_aluwb, row_jal, row_jalr1, row_lui, row_halt;
    initial begin
        row_reset    = ev(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0);
        row_fetch    = ev(0, 1, 1, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0);
        row_memread  = ev(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
        row_memwb    = ev(1, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 0);
        row_memwrite = ev(0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
        row_aluwb    = ev(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
        row_jal      = ev(0, 1, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0, 0);
        row_jalr1    = ev(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0);
        row_lui      = ev(1, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 3'd4, 3'd0, 0);
        row_halt     = ev(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1);
    end

    task automatic push(input logic [17:0] v, input string n);
        exp_t e;
        e.vec  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issues one instruction at the start of its FETCH cycle, queues the
    // expected vector for every cycle it occupies, then waits that long.
    // exp_alu: ALUControl in EXECR/EXECI; exp_taken: PcWrite in BRANCH;
    // exp_nop: instruction is illegal and retires without side effects.
    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z, input logic s, input logic [2:0] exp_alu,
                         input logic exp_taken, input logic exp_nop, input string nm);
        int n;
        op = o; func3 = f3; func7 = f7; Zero = z; sign = s;
        push(row_fetch, {nm, ".fetch"});
        push(ev(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, (o == c_jal) ? 3'd3 : 3'd2, 3'd0, 0),
             {nm, ".decode"});
        n = 2;
        if (exp_nop) begin
            if (o == c_br) begin
                push(ev(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1, 0), {nm, ".branch"});
                n = 3;
            end
        end else begin
            case (o)
                c_ld: begin
                    push(ev(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0), {nm, ".memadr"});
                    push(row_memread, {nm, ".memread"});
                    push(row_memwb, {nm, ".memwb"});
                    n = 5;
                end
                c_st: begin
                    push(ev(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd1, 3'd0, 0), {nm, ".memadr"});
                    push(row_memwrite, {nm, ".memwrite"});
                    n = 4;
                end
                c_r: begin
                    push(ev(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, exp_alu, 0), {nm, ".execr"});
                    push(row_aluwb, {nm, ".aluwb"});
                    n = 4;
                end
                c_i: begin
                    push(ev(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, exp_alu, 0), {nm, ".execi"});
                    push(row_aluwb, {nm, ".aluwb"});
                    n = 4;
                end
                c_br: begin
                    push(ev(0, exp_taken, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1, 0), {nm, ".branch"});
                    n = 3;
                end
                c_jal: begin
                    push(row_jal, {nm, ".jal"});
                    push(row_aluwb, {nm, ".aluwb"});
                    n = 4;
                end
                c_jlr: begin
                    push(row_jalr1, {nm, ".jalr1"});
                    push(row_jal, {nm, ".jalr2"});
                    push(row_aluwb, {nm, ".aluwb"});
                    n = 5;
                end
                c_lui: begin
                    push(row_lui, {nm, ".lui"});
                    n = 3;
                end
                default: ;
            endcase
        end
        step(n);
    endtask

    // Monitor: one comparison per falling edge while expectations are queued.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (w_act !== e.vec) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, w_act, e.vec);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; op = 7'd0; func3 = 3'd0; func7 = 7'd0; Zero = 1'b0; sign = 1'b0;
        @(posedge clk); #1;
        repeat (3) push(row_reset, "reset");
        step(3);
        rst = 1'b1;

        instr(c_ld, 3'b010, 7'd0,        0, 0, 3'd0, 0, 0, "lw");
        instr(c_st, 3'b010, 7'd0,        0, 0, 3'd0, 0, 0, "sw");
        instr(c_r,  3'b000, 7'b0000000,  0, 0, 3'd0, 0, 0, "add");
        instr(c_r,  3'b000, 7'b0100000,  0, 0, 3'd1, 0, 0, "sub");
        instr(c_i,  3'b000, 7'b0100000,  0, 0, 3'd0, 0, 0, "addi_f7");
        instr(c_r,  3'b111, 7'd0,        0, 0, 3'd2, 0, 0, "and");
        instr(c_i,  3'b110, 7'd0,        0, 0, 3'd3, 0, 0, "ori");
        instr(c_i,  3'b100, 7'd0,        0, 0, 3'd4, 0, 0, "xori");
        instr(c_r,  3'b010, 7'd0,        0, 0, 3'd5, 0, 0, "slt");
        instr(c_i,  3'b011, 7'd0,        0, 0, 3'd6, 0, 0, "sltiu");
        instr(c_br, 3'b000, 7'd0,        1, 0, 3'd0, 1, 0, "beq_z1");
        instr(c_br, 3'b000, 7'd0,        0, 0, 3'd0, 0, 0, "beq_z0");
        instr(c_br, 3'b001, 7'd0,        0, 0, 3'd0, 1, 0, "bne_z0");
        instr(c_br, 3'b100, 7'd0,        0, 1, 3'd0, 1, 0, "blt_s1");
        instr(c_br, 3'b101, 7'd0,        0, 1, 3'd0, 0, 0, "bge_s1");
        instr(c_br, 3'b101, 7'd0,        0, 0, 3'd0, 1, 0, "bge_s0");
        instr(c_jal, 3'b000, 7'd0,       0, 0, 3'd0, 0, 0, "jal");
        instr(c_jlr, 3'b000, 7'd0,       0, 0, 3'd0, 0, 0, "jalr");
        instr(c_lui, 3'b000, 7'd0,       0, 0, 3'd0, 0, 0, "lui");

        // Reset asserted while a lw sits in MEMADR: control must return to
        // FETCH at once with every write enable suppressed.
        op = c_ld; func3 = 3'b010; func7 = 7'd0;
        push(row_fetch, "abort.fetch");
        push(ev(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd2, 3'd0, 0), "abort.decode");
        step(2);
        rst = 1'b0;
        push(row_reset, "abort.reset0");
        push(row_reset, "abort.reset1");
        step(2);
        rst = 1'b1;
        instr(c_lui, 3'b000, 7'd0, 0, 0, 3'd0, 0, 0, "lui_after_abort");

`ifdef CTRL_ILLEGAL_TRAP_EN
        op = c_bad; func3 = 3'd0; func7 = 7'd0;
        push(row_fetch, "trap.fetch");
        push(ev(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd2, 3'd0, 0), "trap.decode");
        repeat (3) push(row_halt, "trap.halt");
        step(5);
        rst = 1'b0;
        push(row_reset, "trap.reset");
        step(1);
        rst = 1'b1;
        instr(c_lui, 3'b000, 7'd0, 0, 0, 3'd0, 0, 0, "lui_after_trap");
`else
        instr(c_bad, 3'b000, 7'd0, 0, 0, 3'd0, 0, 1, "bad_op");
        instr(c_r,   3'b001, 7'd0, 0, 0, 3'd0, 0, 1, "sll_nop");
        instr(c_br,  3'b010, 7'd0, 1, 0, 3'd0, 0, 1, "br_f3_nop");
        instr(c_ld,  3'b010, 7'd0, 0, 0, 3'd0, 0, 0, "lw_after_nop");
`endif

        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Main control unit for the RV32I multi-cycle core. Sequences the shared-memory datapath through fetch, decode, execute, memory and writeback cycles by driving all register enables and mux selects from a Moore state machine, plus a combinational branch-resolve term. Consumes opcode, funct3, funct7, Zero and sign from the datapath.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- op  in  7  opcode, Inst[6:0]
- func3  in  3  Inst[14:12]
- func7  in  7  Inst[31:25]
- Zero, sign  in  1 each  ALU result ==0 / ALU result bit 31
- RegWrite, PcWrite, IrWrite, AdrSrc, MemWrite  out  1 each  enables/selects
- ResultSrc  out  2  0 ALUOut, 1 Data, 2 ALUResult, 3 ImmExt
- ALUSrcA  out  2  0 PC, 1 OldPc, 2 A
- ALUSrcB  out  2  0 B, 1 ImmExt, 2 constant 4
- ImmSrc  out  3  0 I, 1 S, 2 B, 3 J, 4 U
- ALUControl  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU
- illegal  out  1  sticky illegal-instruction flag

## Operation
- FETCH: AdrSrc=0, IrWrite=1, SrcA=PC, SrcB=4, ADD, ResultSrc=2, PcWrite=1 -> DECODE.
- DECODE: SrcA=OldPc, SrcB=Imm, ADD (ALUOut=target); ImmSrc=J if op=jal else B. Next by op: lw/sw->MEMADR, R->EXECR, I-ALU->EXECI, branch->BRANCH, jal->JAL, jalr->JALR1, lui->LUI, else illegal handling.
- MEMADR: SrcA=A, SrcB=Imm, ImmSrc=I (lw) or S (sw), ADD -> MEMREAD (lw) / MEMWRITE (sw).
- MEMREAD: AdrSrc=1, ResultSrc=0 -> MEMWB. MEMWB: ResultSrc=1, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=0, MemWrite=1 -> FETCH.
- EXECR: SrcA=A, SrcB=B, ALUControl from funct decode -> ALUWB. EXECI: SrcA=A, SrcB=Imm, ImmSrc=I -> ALUWB.
- ALUWB: ResultSrc=0, RegWrite=1 -> FETCH.
- BRANCH: SrcA=A, SrcB=B, SUB, ResultSrc=0; PcWrite = taken: beq Zero, bne !Zero, blt sign, bge !sign; other funct3 illegal -> FETCH.
- JAL: SrcA=OldPc, SrcB=4, ADD, ResultSrc=0, PcWrite=1 -> ALUWB (rd=OldPc+4).
- JALR1: SrcA=A, SrcB=Imm, ImmSrc=I, ADD -> JALR2. JALR2: as JAL -> ALUWB.
- LUI: ImmSrc=U, ResultSrc=3, RegWrite=1 -> FETCH.
- Funct decode: funct3 000 ADD, or SUB when R-type and func7[5]=1; 111 AND; 110 OR; 100 XOR; 010 SLT; 011 SLTU; 001/101 (shifts) illegal.
- Unlisted signals in a state are 0; selects default 0.

## Timing
- Cycles per instruction: lw 5, sw 4, R/I-ALU 4, branch 3, jal 4, jalr 5, lui 3.
- All outputs are functions of state register only, except BRANCH PcWrite (combinational on Zero/sign, same cycle).
- Reset: state=FETCH, illegal=0; while rst=0, RegWrite, PcWrite, IrWrite, MemWrite forced 0. First fetch on first rising edge after rst release.
- Reset mid-instruction aborts immediately; no partial write after assertion.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: illegal opcode/funct in DECODE/BRANCH -> HALT state; all enables 0; illegal=1 until reset.
- Undefined: illegal instructions return to FETCH as a NOP (no register, memory or extra PC write); illegal tied 0.

## Structure
- Package riscv_ctrl_pkg: state enum, opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111), ALUControl, ImmSrc, ResultSrc, ALUSrcA/B encodings.
- One sub-module: alu_decoder (op, func3, func7 -> ALUControl, funct-illegal).

## Test plan
- Reset held 3 cycles, release -> state FETCH, PcWrite=1, IrWrite=1 on first cycle; all write enables 0 during reset.
- lw (op 0000011) -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 with ResultSrc=1 in cycle 5 only.
- sub (func7=0100000, func3=000) -> ALUControl=1 in EXECR; add (func7=0) -> 0; RegWrite in cycle 4.
- beq with Zero=1 -> PcWrite=1 in cycle 3; Zero=0 -> 0; blt sign=1 -> 1; bge sign=1 -> 0.
- jalr -> 5 cycles; PcWrite in JALR2 with ResultSrc=0; RegWrite in ALUWB.
- op 1111111 -> with CTRL_ILLEGAL_TRAP_EN: illegal=1, no enables until reset; without: back to FETCH after 2 cycles, no writes.
